// File: rtl/snapshot_sram_bridge.sv
// Converts the snapshot block's held request/acknowledge interface into single-cycle
// accesses on a single-port SRAM, sweeping every entry to RST_VALUE after reset.
module snapshot_sram_bridge #(
    parameter int                   MEM_WIDTH   = 36,
    parameter int                   ENTRY_WIDTH = 7,
    parameter int                   RD_LATENCY  = 1,
    parameter logic [MEM_WIDTH-1:0] RST_VALUE   = {MEM_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   soft_rst,
    input  logic                   mem_req_vld,
    output logic                   mem_ack_vld,
    input  logic [ENTRY_WIDTH-1:0] mem_addr,
    input  logic                   mem_wr_en,
    input  logic                   mem_rd_en,
    input  logic [MEM_WIDTH-1:0]   mem_wr_data,
    output logic [MEM_WIDTH-1:0]   mem_rd_data,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [ENTRY_WIDTH-1:0] sram_addr,
    output logic [MEM_WIDTH-1:0]   sram_wdata,
    input  logic [MEM_WIDTH-1:0]   sram_rdata,
    output logic                   init_done,
    output logic                   err
);

    localparam int                     LAT_W      = 2;
    localparam logic [LAT_W-1:0]       LAT_LOAD   = LAT_W'(RD_LATENCY - 1);
    localparam logic [ENTRY_WIDTH-1:0] LAST_ENTRY = {ENTRY_WIDTH{1'b1}};

    typedef enum logic [5:0] {
        S_INIT   = 6'b000001,
        S_IDLE   = 6'b000010,
        S_ACCESS = 6'b000100,
        S_WAIT   = 6'b001000,
        S_ACK    = 6'b010000,
        S_GAP    = 6'b100000
    } state_t;

    state_t                 state_reg, state_next;
    logic [ENTRY_WIDTH-1:0] init_cnt_reg, init_cnt_next;
    logic                   init_wrap_reg, init_wrap_next;
    logic [LAT_W-1:0]       lat_cnt_reg, lat_cnt_next;
    logic [ENTRY_WIDTH-1:0] addr_reg, addr_next;
    logic                   wr_en_reg, wr_en_next;
    logic                   rd_en_reg, rd_en_next;
    logic [MEM_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                   init_done_reg, init_done_next;
    logic [MEM_WIDTH-1:0]   rd_data_reg, rd_data_next;
    logic                   ack_reg, ack_next;
    logic                   err_reg, err_next;
    logic                   sram_cs_reg, sram_cs_next;
    logic                   sram_we_reg, sram_we_next;
    logic [ENTRY_WIDTH-1:0] sram_addr_reg, sram_addr_next;
    logic [MEM_WIDTH-1:0]   sram_wdata_reg, sram_wdata_next;

    // SRAM strobes are registered from the next state, so in any cycle they reflect
    // the current state while staying low during reset.
    always_comb begin
        state_next      = state_reg;
        init_cnt_next   = init_cnt_reg;
        init_wrap_next  = init_wrap_reg;
        lat_cnt_next    = lat_cnt_reg;
        addr_next       = addr_reg;
        wr_en_next      = wr_en_reg;
        rd_en_next      = rd_en_reg;
        wdata_next      = wdata_reg;
        init_done_next  = init_done_reg;
        rd_data_next    = rd_data_reg;
        ack_next        = 1'b0;
        err_next        = 1'b0;
        sram_cs_next    = 1'b0;
        sram_we_next    = 1'b0;
        sram_addr_next  = sram_addr_reg;
        sram_wdata_next = sram_wdata_reg;

        case (state_reg)
            S_INIT: begin
                // The wrap flag acts as the sweep counter's carry: one extra INIT
                // cycle after the last write, then IDLE.
                if (init_wrap_reg) begin
                    state_next     = S_IDLE;
                    init_done_next = 1'b1;
                    init_wrap_next = 1'b0;
                end else begin
                    sram_cs_next    = 1'b1;
                    sram_we_next    = 1'b1;
                    sram_addr_next  = init_cnt_reg;
                    sram_wdata_next = RST_VALUE;
                    init_cnt_next   = init_cnt_reg + 1'b1;
                    init_wrap_next  = (init_cnt_reg == LAST_ENTRY);
                end
            end
            S_IDLE: begin
                if (!soft_rst && mem_req_vld) begin
                    addr_next  = mem_addr;
                    wr_en_next = mem_wr_en;
                    rd_en_next = mem_rd_en;
                    wdata_next = mem_wr_data;
                    if (mem_wr_en ^ mem_rd_en) begin
                        state_next      = S_ACCESS;
                        sram_cs_next    = 1'b1;
                        sram_we_next    = mem_wr_en;
                        sram_addr_next  = mem_addr;
                        sram_wdata_next = mem_wr_data;
                    end else begin
                        state_next = S_ACK;
                        ack_next   = 1'b1;
                        err_next   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (soft_rst) begin
                    state_next = S_IDLE;
                end else if (rd_en_reg) begin
                    state_next   = S_WAIT;
                    lat_cnt_next = LAT_LOAD;
                end else begin
                    state_next = S_ACK;
                    ack_next   = 1'b1;
                end
            end
            S_WAIT: begin
                if (soft_rst) begin
                    state_next = S_IDLE;
                end else if (lat_cnt_reg == '0) begin
                    rd_data_next = sram_rdata;
                    state_next   = S_ACK;
                    ack_next     = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 1'b1;
                end
            end
            S_ACK: begin
                state_next = soft_rst ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_INIT;
            init_cnt_reg   <= '0;
            init_wrap_reg  <= 1'b0;
            lat_cnt_reg    <= '0;
            addr_reg       <= '0;
            wr_en_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            wdata_reg      <= '0;
            init_done_reg  <= 1'b0;
            rd_data_reg    <= '0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            sram_cs_reg    <= 1'b0;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            init_cnt_reg   <= init_cnt_next;
            init_wrap_reg  <= init_wrap_next;
            lat_cnt_reg    <= lat_cnt_next;
            addr_reg       <= addr_next;
            wr_en_reg      <= wr_en_next;
            rd_en_reg      <= rd_en_next;
            wdata_reg      <= wdata_next;
            init_done_reg  <= init_done_next;
            rd_data_reg    <= rd_data_next;
            ack_reg        <= ack_next;
            err_reg        <= err_next;
            sram_cs_reg    <= sram_cs_next;
            sram_we_reg    <= sram_we_next;
            sram_addr_reg  <= sram_addr_next;
            sram_wdata_reg <= sram_wdata_next;
        end
    end

    assign mem_ack_vld = ack_reg;
    assign err         = err_reg;
    assign init_done   = init_done_reg;
    assign mem_rd_data = rd_data_reg;
    assign sram_cs     = sram_cs_reg;
    assign sram_we     = sram_we_reg;
    assign sram_addr   = sram_addr_reg;
    assign sram_wdata  = sram_wdata_reg;

endmodule

// File: tb/tb_snapshot_sram_bridge.sv
// Directed bench for snapshot_sram_bridge: two instances (read latency 2 and 4),
// each with a behavioural SRAM model.
module tb_snapshot_sram_bridge;

    localparam logic [35:0] RV = 36'h5_A5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        soft_rst = 1'b0;
    logic        req2 = 1'b0;
    logic        req4 = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [6:0]  addr = '0;
    logic [35:0] wdata = '0;

    logic        ack2, cs2, we2, done2, err2;
    logic [6:0]  saddr2;
    logic [35:0] rdd2, swdata2, srdata2;
    logic        ack4, cs4, we4, done4, err4;
    logic [6:0]  saddr4;
    logic [35:0] rdd4, swdata4, srdata4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    snapshot_sram_bridge #(.MEM_WIDTH(36), .ENTRY_WIDTH(7), .RD_LATENCY(2), .RST_VALUE(RV)) dut2 (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .mem_req_vld(req2), .mem_ack_vld(ack2),
        .mem_addr(addr), .mem_wr_en(wr_en), .mem_rd_en(rd_en), .mem_wr_data(wdata),
        .mem_rd_data(rdd2), .sram_cs(cs2), .sram_we(we2), .sram_addr(saddr2),
        .sram_wdata(swdata2), .sram_rdata(srdata2), .init_done(done2), .err(err2)
    );

    snapshot_sram_bridge #(.MEM_WIDTH(36), .ENTRY_WIDTH(7), .RD_LATENCY(4), .RST_VALUE(RV)) dut4 (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .mem_req_vld(req4), .mem_ack_vld(ack4),
        .mem_addr(addr), .mem_wr_en(wr_en), .mem_rd_en(rd_en), .mem_wr_data(wdata),
        .mem_rd_data(rdd4), .sram_cs(cs4), .sram_we(we4), .sram_addr(saddr4),
        .sram_wdata(swdata4), .sram_rdata(srdata4), .init_done(done4), .err(err4)
    );

    // SRAM models: read data appears RD_LATENCY cycles after the cs cycle, X otherwise
    logic [35:0] mem2 [128];
    logic [35:0] pipe2 [2];
    logic [35:0] mem4 [128];
    logic [35:0] pipe4 [4];

    always @(posedge clk) begin
        if (cs2 && we2) mem2[saddr2] <= swdata2;
        pipe2[0] <= (cs2 && !we2) ? mem2[saddr2] : {36{1'bx}};
        pipe2[1] <= pipe2[0];
        if (cs4 && we4) mem4[saddr4] <= swdata4;
        pipe4[0] <= (cs4 && !we4) ? mem4[saddr4] : {36{1'bx}};
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign srdata2 = pipe2[1];
    assign srdata4 = pipe4[3];

    // Init sweep and access monitor for the latency-2 instance
    int init_wr2 = 0;
    int init_bad2 = 0;
    int acc2 = 0;
    int we_bad2 = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            init_wr2  <= 0;
            init_bad2 <= 0;
        end else if (cs2 && !done2) begin
            if (!(we2 && saddr2 == init_wr2[6:0] && swdata2 == RV)) init_bad2 <= init_bad2 + 1;
            init_wr2 <= init_wr2 + 1;
        end
        if (cs2 && done2) acc2 <= acc2 + 1;
        if (!cs2 && we2) we_bad2 <= we_bad2 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise a request at the current negedge and wait (bounded) for its ack
    task automatic xact(input bit use4, input bit w, input bit r, input logic [6:0] a,
                        input logic [35:0] d, output int lat, output logic e,
                        output logic [35:0] q, output int ncs);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        if (use4) req4 = 1'b1;
        else      req2 = 1'b1;
        lat = -1;
        e   = 1'bx;
        q   = {36{1'bx}};
        ncs = 0;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(negedge clk);
            ncs += use4 ? int'(cs4) : int'(cs2);
            if ((use4 ? ack4 : ack2) === 1'b1) begin
                lat = k;
                e   = use4 ? err4 : err2;
                q   = use4 ? rdd4 : rdd2;
            end
        end
        req2 = 1'b0;
        req4 = 1'b0;
        $display("[TB] xact lat%0d wr=%0b rd=%0b addr=%02h wdata=%09h -> ack_after=%0d err=%0b rdata=%09h sram_cycles=%0d",
                 use4 ? 4 : 2, w, r, a, d, lat, e, q, ncs);
    endtask

    task automatic idle2();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, ncs, done_at, acc_at, ack_at, nack, a0;
        logic e, ack_err;
        logic [35:0] q;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack2), 64'd0);
        chk("rst_err", 64'(err2), 64'd0);
        chk("rst_init_done", 64'(done2), 64'd0);
        chk("rst_rd_data", 64'(rdd2), 64'd0);
        chk("rst_sram_cs", 64'(cs2), 64'd0);
        chk("rst_sram_we", 64'(we2), 64'd0);
        chk("rst_sram_addr", 64'(saddr2), 64'd0);
        chk("rst_sram_wdata", 64'(swdata2), 64'd0);

        // Init sweep with a write request held from cycle 10
        rst_n   = 1'b1;
        done_at = -1;
        acc_at  = -1;
        ack_at  = -1;
        ack_err = 1'bx;
        for (int c = 0; c < 136; c++) begin
            @(negedge clk);
            if (c == 10) begin
                wr_en = 1'b1; rd_en = 1'b0; addr = 7'h33; wdata = 36'h3_3333_3333; req2 = 1'b1;
            end
            if (done2 === 1'b1 && done_at < 0) done_at = c;
            if (cs2 === 1'b1 && swdata2 === 36'h3_3333_3333 && acc_at < 0) acc_at = c;
            if (ack2 === 1'b1 && ack_at < 0) begin
                ack_at = c; ack_err = err2; req2 = 1'b0;
            end
        end
        $display("[TB] init: done_at=%0d writes=%0d held_req access_at=%0d ack_at=%0d", done_at, init_wr2, acc_at, ack_at);
        chk("init_done_cycle", 64'(done_at), 64'd128);
        chk("init_write_count", 64'(init_wr2), 64'd128);
        chk("init_write_pattern", 64'(init_bad2), 64'd0);
        chk("held_req_access_cycle", 64'(acc_at), 64'd129);
        chk("held_req_ack_cycle", 64'(ack_at), 64'd130);
        chk("held_req_err", 64'(ack_err), 64'd0);

        // Write then read, latency 2
        xact(1'b0, 1'b1, 1'b0, 7'h15, 36'hF_1234_5678, lat, e, q, ncs);
        chk("wr_ack_latency", 64'(lat), 64'd2);
        chk("wr_err", 64'(e), 64'd0);
        chk("wr_sram_cycles", 64'(ncs), 64'd1);
        idle2();
        xact(1'b0, 1'b0, 1'b1, 7'h15, 36'h0, lat, e, q, ncs);
        chk("rd_ack_latency", 64'(lat), 64'd4);
        chk("rd_data_at_ack", 64'(q), 64'hF_1234_5678);
        chk("rd_err", 64'(e), 64'd0);
        chk("rd_sram_cycles", 64'(ncs), 64'd1);
        @(negedge clk);
        chk("rd_data_hold", 64'(rdd2), 64'hF_1234_5678);
        @(negedge clk);

        // Illegal requests: both enables, then neither
        xact(1'b0, 1'b1, 1'b1, 7'h15, 36'h0_DEAD_BEEF, lat, e, q, ncs);
        chk("ill_both_latency", 64'(lat), 64'd1);
        chk("ill_both_err", 64'(e), 64'd1);
        chk("ill_both_rd_data", 64'(q), 64'hF_1234_5678);
        chk("ill_both_sram_cycles", 64'(ncs), 64'd0);
        idle2();
        xact(1'b0, 1'b0, 1'b0, 7'h15, 36'h0_DEAD_BEEF, lat, e, q, ncs);
        chk("ill_none_latency", 64'(lat), 64'd1);
        chk("ill_none_err", 64'(e), 64'd1);
        chk("ill_none_rd_data", 64'(q), 64'hF_1234_5678);
        chk("ill_none_sram_cycles", 64'(ncs), 64'd0);
        idle2();

        // Back-to-back: re-raise during GAP, accepted in the following IDLE
        a0 = acc2;
        xact(1'b0, 1'b1, 1'b0, 7'h20, 36'hA_BCDE_0123, lat, e, q, ncs);
        chk("b2b_wr_latency", 64'(lat), 64'd2);
        @(negedge clk);
        xact(1'b0, 1'b0, 1'b1, 7'h20, 36'h0, lat, e, q, ncs);
        chk("b2b_rd_latency", 64'(lat), 64'd5);
        chk("b2b_rd_data", 64'(q), 64'hA_BCDE_0123);
        chk("b2b_rd_sram_cycles", 64'(ncs), 64'd1);
        chk("b2b_total_accesses", 64'(acc2 - a0), 64'd2);
        idle2();

        // soft_rst mid-read on the latency-4 instance
        xact(1'b1, 1'b1, 1'b0, 7'h40, 36'h1_0000_0001, lat, e, q, ncs);
        chk("l4_wr_latency", 64'(lat), 64'd2);
        idle2();
        xact(1'b1, 1'b0, 1'b1, 7'h40, 36'h0, lat, e, q, ncs);
        chk("l4_rd_latency", 64'(lat), 64'd6);
        chk("l4_rd_data", 64'(q), 64'h1_0000_0001);
        idle2();
        xact(1'b1, 1'b1, 1'b0, 7'h41, 36'h2_2222_2222, lat, e, q, ncs);
        idle2();
        wr_en = 1'b0; rd_en = 1'b1; addr = 7'h41; req4 = 1'b1;
        nack = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ack4 !== 1'b0) nack++;
            if (k == 3) begin soft_rst = 1'b1; req4 = 1'b0; end
            if (k == 4) soft_rst = 1'b0;
        end
        $display("[TB] soft_rst during WAIT: acks_seen=%0d rd_data=%09h", nack, rdd4);
        chk("sr_no_ack", 64'(nack), 64'd0);
        chk("sr_rd_data_kept", 64'(rdd4), 64'h1_0000_0001);
        xact(1'b1, 1'b0, 1'b1, 7'h41, 36'h0, lat, e, q, ncs);
        chk("sr_next_rd_latency", 64'(lat), 64'd6);
        chk("sr_next_rd_data", 64'(q), 64'h2_2222_2222);
        idle2();

        // rst_n mid-init at counter 50, soft_rst pulsed during the restarted sweep
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 50; c++) @(negedge clk);
        chk("mid_init_addr", 64'(saddr2), 64'd50);
        chk("mid_init_done_low", 64'(done2), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_sram_cs", 64'(cs2), 64'd0);
        chk("mid_rst_sram_addr", 64'(saddr2), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        done_at = -1;
        for (int c = 0; c < 136; c++) begin
            @(negedge clk);
            if (c == 20) soft_rst = 1'b1;
            if (c == 31) soft_rst = 1'b0;
            if (done2 === 1'b1 && done_at < 0) done_at = c;
        end
        $display("[TB] re-init: done_at=%0d writes=%0d", done_at, init_wr2);
        chk("reinit_done_cycle", 64'(done_at), 64'd128);
        chk("reinit_write_count", 64'(init_wr2), 64'd128);
        chk("reinit_write_pattern", 64'(init_bad2), 64'd0);
        xact(1'b0, 1'b0, 1'b1, 7'h15, 36'h0, lat, e, q, ncs);
        chk("reinit_rd_lat2", 64'(q), 64'(RV));
        idle2();
        xact(1'b1, 1'b0, 1'b1, 7'h41, 36'h0, lat, e, q, ncs);
        chk("reinit_rd_lat4", 64'(q), 64'(RV));
        chk("we_without_cs", 64'(we_bad2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
